// File: rtl/eh2_dec_gpr_bank.sv
// eh2_dec_gpr_bank
// Per-thread integer register file for the decode stage. Entry 0 reads as
// zero and has no storage. Writes go through clock-gated enable flops; when
// several ports hit the same entry in one cycle the highest-numbered port
// wins, and a registered flag reports the conflict one cycle later. A clear
// sequencer walks entries 1..DEPTH-1 writing zero after reset or on
// clear_req; reads return 0 and port writes are dropped while it runs.
//
// Optional feature macro: RV_GPR_BYPASS_EN
//   defined   : a valid read sees a valid same-cycle write to its address
//               (highest write port wins); inactive while busy.
//   undefined : reads return stored contents only.
//
// Ports
//   clk, rst_l        clock, asynchronous active-low reset
//   scan_mode         forces the storage clock gates open
//   tid               thread owned by this instance
//   raddr/rtid/rden   read address, thread id, enable per read port
//   rd                read data per read port (combinational)
//   waddr/wtid/wen/wd write address, thread id, enable, data per write port
//   clear_req         one-cycle request to zero the bank
//   busy              clear sequence in progress
//   wr_collision      same-entry write conflict seen in the previous cycle
module eh2_dec_gpr_bank #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 32,
   parameter int NRD   = 4,
   parameter int NWR   = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst_l,
   input  logic                      scan_mode,
   input  logic                      tid,
   input  logic [NRD-1:0][AW-1:0]    raddr,
   input  logic [NRD-1:0]            rtid,
   input  logic [NRD-1:0]            rden,
   output logic [NRD-1:0][XLEN-1:0]  rd,
   input  logic [NWR-1:0][AW-1:0]    waddr,
   input  logic [NWR-1:0]            wtid,
   input  logic [NWR-1:0]            wen,
   input  logic [NWR-1:0][XLEN-1:0]  wd,
   input  logic                      clear_req,
   output logic                      busy,
   output logic                      wr_collision
);

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   cidx_q, cidx_d;
   logic            coll_q, coll_d;
   logic            clr_act;

   logic [NWR-1:0]   wvld;
   logic [DEPTH-1:1] ent_en;
   logic [XLEN-1:0]  ent_din [1:DEPTH-1];
   logic [XLEN-1:0]  mem_q   [1:DEPTH-1];

   // Control state register
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q <= CLEAR;
         cidx_q  <= AW'(1);
         coll_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cidx_q  <= cidx_d;
         coll_q  <= coll_d;
      end
   end

   // Clear sequencer next state; clear_req is ignored while already clearing
   always_comb begin
      state_d = state_q;
      cidx_d  = cidx_q;
      case (state_q)
         CLEAR: begin
            if (cidx_q == AW'(DEPTH-1)) state_d = IDLE;
            else                        cidx_d  = cidx_q + AW'(1);
         end
         default: begin
            if (clear_req) begin
               state_d = CLEAR;
               cidx_d  = AW'(1);
            end
         end
      endcase
   end

   // Clear sequencer outputs
   always_comb begin
      clr_act      = (state_q == CLEAR);
      busy         = clr_act;
      wr_collision = coll_q;
   end

   // Write port qualification and same-entry conflict detection.
   // Port writes are dropped outright during a clear, so they cannot collide.
   always_comb begin
      coll_d = 1'b0;
      for (int k = 0; k < NWR; k++) begin
         wvld[k] = wen[k] & (wtid[k] == tid) & (waddr[k] != '0) & ~clr_act;
      end
      for (int k = 0; k < NWR; k++) begin
         for (int m = k + 1; m < NWR; m++) begin
            if (wvld[k] && wvld[m] && (waddr[k] == waddr[m])) coll_d = 1'b1;
         end
      end
   end

   // Per-entry enable and data; later ports overwrite earlier ones so the
   // highest-numbered valid port wins. Data defaults to the held value.
   always_comb begin
      for (int j = 1; j < DEPTH; j++) begin
         ent_en[j]  = 1'b0;
         ent_din[j] = mem_q[j];
         for (int k = 0; k < NWR; k++) begin
            if (wvld[k] && (waddr[k] == AW'(j))) begin
               ent_en[j]  = 1'b1;
               ent_din[j] = wd[k];
            end
         end
         if (clr_act && (cidx_q == AW'(j))) begin
            ent_en[j]  = 1'b1;
            ent_din[j] = '0;
         end
      end
   end

   // Storage: enable flops, no reset. scan_mode opens the gate as a clock
   // header would; the held-value default keeps contents unchanged then.
   always_ff @(posedge clk) begin
      for (int j = 1; j < DEPTH; j++) begin
         if (ent_en[j] | scan_mode) mem_q[j] <= ent_din[j];
      end
   end

   // Combinational read ports
   always_comb begin
      for (int i = 0; i < NRD; i++) begin
         rd[i] = '0;
         if (rden[i] && (rtid[i] == tid) && (raddr[i] != '0) && !clr_act) begin
            for (int j = 1; j < DEPTH; j++) begin
               if (raddr[i] == AW'(j)) rd[i] = mem_q[j];
            end
`ifdef RV_GPR_BYPASS_EN
            for (int k = 0; k < NWR; k++) begin
               if (wvld[k] && (waddr[k] == raddr[i])) rd[i] = wd[k];
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_eh2_dec_gpr_bank.sv
module tb_eh2_dec_gpr_bank;

   localparam int XLEN  = 32;
   localparam int DEPTH = 32;
   localparam int NRD   = 4;
   localparam int NWR   = 4;
   localparam int AW    = 5;

   logic                     clk = 1'b0;
   logic                     rst_l = 1'b0;
   logic                     scan_mode = 1'b0;
   logic                     tid = 1'b0;
   logic [NRD-1:0][AW-1:0]   raddr;
   logic [NRD-1:0]           rtid;
   logic [NRD-1:0]           rden;
   logic [NRD-1:0][XLEN-1:0] rd;
   logic [NWR-1:0][AW-1:0]   waddr;
   logic [NWR-1:0]           wtid;
   logic [NWR-1:0]           wen;
   logic [NWR-1:0][XLEN-1:0] wd;
   logic                     clear_req;
   logic                     busy;
   logic                     wr_collision;

   eh2_dec_gpr_bank #(.XLEN(XLEN), .DEPTH(DEPTH), .NRD(NRD), .NWR(NWR)) dut (
      .clk          (clk),
      .rst_l        (rst_l),
      .scan_mode    (scan_mode),
      .tid          (tid),
      .raddr        (raddr),
      .rtid         (rtid),
      .rden         (rden),
      .rd           (rd),
      .waddr        (waddr),
      .wtid         (wtid),
      .wen          (wen),
      .wd           (wd),
      .clear_req    (clear_req),
      .busy         (busy),
      .wr_collision (wr_collision)
   );

   always #10 clk = ~clk;

   typedef struct {
      string       tag;
      int          sel;   // 0..NRD-1 read port, NRD busy, NRD+1 wr_collision
      logic [31:0] exp;
   } sb_t;

   sb_t sb[$];
   int  checks   = 0;
   int  failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_sig(input string tag, input int sel, input logic [31:0] e);
      sb.push_back('{tag, sel, e});
   endtask

   // Let combinational outputs settle, then compare everything queued.
   task automatic drain();
      sb_t         s;
      logic [31:0] o;
      #1;
      while (sb.size() > 0) begin
         s = sb.pop_front();
         if (s.sel < NRD)       o = rd[s.sel];
         else if (s.sel == NRD) o = {31'b0, busy};
         else                   o = {31'b0, wr_collision};
         check(s.tag, o, s.exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wen = '0; waddr = '0; wtid = '0; wd = '0;
      rden = '0; raddr = '0; rtid = '0;
      clear_req = 1'b0;
   endtask

   task automatic wr(input int p, input int a, input logic [31:0] d, input logic t = 1'b0);
      wen[p] = 1'b1; waddr[p] = AW'(a); wd[p] = d; wtid[p] = t;
   endtask

   task automatic rdx(input string tag, input int p, input int a, input logic [31:0] e,
                      input logic t = 1'b0);
      rden[p] = 1'b1; raddr[p] = AW'(a); rtid[p] = t;
      expect_sig(tag, p, e);
   endtask

   // Counts edges from the starting point until busy drops (bounded).
   task automatic wait_clear(input string tag, input bit drop_wr);
      int n    = 0;
      bit done = 1'b0;
      while (!done && n < 100) begin
         tick();
         n++;
         idle();
         if (drop_wr && n == 10) wr(0, 4, 32'h4444_4444);
         if (busy == 1'b0) done = 1'b1;
      end
      check(tag, 32'(n), 32'd31);
   endtask

   task automatic read_all_zero(input string tag);
      for (int g = 0; g < DEPTH / NRD; g++) begin
         idle();
         for (int p = 0; p < NRD; p++) rdx(tag, p, g * NRD + p, 32'h0);
         drain();
      end
   endtask

   function automatic logic [31:0] fill_val(input int j);
      return 32'h0101_0101 * 32'(j);
   endfunction

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      #12;
      expect_sig("rst_busy", NRD, 32'd1);
      expect_sig("rst_coll", NRD + 1, 32'd0);
      drain();
      @(posedge clk);
      #1;
      rst_l = 1'b1;
      rdx("busy_rd_zero", 0, 3, 32'h0);
      expect_sig("busy_after_rel", NRD, 32'd1);
      drain();
      wait_clear("rst_clear_len", 1'b0);
      read_all_zero("post_rst_zero");

      // simple write, then read next cycle
      idle(); wr(2, 5, 32'hDEAD_BEEF);
      tick(); idle();
      rdx("wr_x5", 0, 5, 32'hDEAD_BEEF);
      drain();

      // x0 stays zero
      idle(); wr(1, 0, 32'hFFFF_FFFF);
      tick(); idle();
      rdx("rd_x0", 1, 0, 32'h0);
      expect_sig("x0_no_coll", NRD + 1, 32'd0);
      drain();

      // two ports, different entries: no conflict
      idle(); wr(0, 10, 32'h0000_AAAA); wr(1, 11, 32'h0000_BBBB);
      tick(); idle();
      rdx("wr_x10", 0, 10, 32'h0000_AAAA);
      rdx("wr_x11", 1, 11, 32'h0000_BBBB);
      expect_sig("diff_no_coll", NRD + 1, 32'd0);
      drain();

      // same-entry conflict: port 3 wins, one-cycle flag
      idle(); wr(0, 7, 32'h0000_1111); wr(3, 7, 32'h0000_3333);
      tick(); idle();
      rdx("coll_prio", 0, 7, 32'h0000_3333);
      expect_sig("coll_set", NRD + 1, 32'd1);
      drain();
      tick(); idle();
      expect_sig("coll_clr", NRD + 1, 32'd0);
      drain();

      // foreign thread writes and reads
      idle(); wr(0, 9, 32'h0000_9999, 1'b1); wr(1, 9, 32'h0000_7777, 1'b1);
      tick(); idle();
      rdx("foreign_wr_x9", 0, 9, 32'h0);
      rdx("foreign_rd", 1, 5, 32'h0, 1'b1);
      rdx("own_rd_x5", 2, 5, 32'hDEAD_BEEF);
      expect_sig("foreign_no_coll", NRD + 1, 32'd0);
      drain();

      // fill x1..x31 with nonzero data
      for (int j = 1; j < DEPTH; j += NWR) begin
         idle();
         for (int p = 0; p < NWR; p++) if (j + p < DEPTH) wr(p, j + p, fill_val(j + p));
         tick();
      end
      idle();
      rdx("fill_x1", 0, 1, fill_val(1));
      rdx("fill_x16", 1, 16, fill_val(16));
      rdx("fill_x31", 2, 31, fill_val(31));
      rdx("fill_x7", 3, 7, fill_val(7));
      drain();

      // requested clear with a dropped write to x4 mid-sequence
      idle(); clear_req = 1'b1;
      tick(); idle();
      expect_sig("req_busy", NRD, 32'd1);
      rdx("req_busy_rd", 0, 16, 32'h0);
      drain();
      wait_clear("req_clear_len", 1'b1);
      read_all_zero("post_req_zero");
      idle();
      rdx("dropped_wr_x4", 0, 4, 32'h0);
      expect_sig("clear_no_coll", NRD + 1, 32'd0);
      drain();

      // reset in the middle of a clear restarts the full sequence
      idle(); clear_req = 1'b1;
      tick(); idle();
      tick(); tick(); tick();
      rst_l = 1'b0;
      expect_sig("mid_rst_busy", NRD, 32'd1);
      drain();
      @(negedge clk);
      rst_l = 1'b1;
      wait_clear("mid_rst_len", 1'b0);

      // same-cycle write and read of x12
      idle(); wr(0, 12, 32'h0000_0012);
      tick(); idle();
      wr(1, 12, 32'hA5A5_A5A5);
`ifdef RV_GPR_BYPASS_EN
      rdx("same_cycle_x12", 0, 12, 32'hA5A5_A5A5);
`else
      rdx("same_cycle_x12", 0, 12, 32'h0000_0012);
`endif
      drain();
      tick(); idle();
      rdx("after_x12", 0, 12, 32'hA5A5_A5A5);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
